spi_reg_bank: RTL and testbench

//  SPI mode-0 slave register file between the SCLK/SSEL/MOSI/MISO pins and the
//  vga/pwm consumers. Oversamples the SPI pins in the clk domain, decodes
//  {rw,addr} command bytes and data bytes, and holds NUM_REGS 8-bit control

---
 rtl/spi_regs_pkg.sv | 22 ++
 rtl/sync_edge.sv | 41 ++++
 rtl/spi_reg_bank.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register bank.
//   ADDR_W      width of the register address carried in a command byte
//   CMD_RW_BIT  bit of the command byte that selects read (1) or write (0)
//   spi_state_e bus FSM states
//   addr_mapped true when an address falls inside the implemented register range
package spi_regs_pkg;

   localparam int ADDR_W     = 7;
   localparam int CMD_RW_BIT = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } spi_state_e;

   function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr,
                                        input int num_regs);
      return int'(addr) < num_regs;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin followed by one delay flop
// for edge detection. A pin edge shows up on rise/fall two clocks after it
// is captured, so logic acting on the pulse responds on the third clock.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (all flops load RESET_VAL)
//   din    in  asynchronous pin
//   level  out synchronised pin level
//   rise   out one-clock pulse on a synchronised 0->1 transition
//   fall   out one-clock pulse on a synchronised 1->0 transition
module sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level = sync_q;
   assign rise  = sync_q & ~prev_q;
   assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register file. The SPI pins are oversampled in the clk
// domain; the first byte of a transaction is a {rw, addr} command, following
// bytes are data written to (rw=0) or read from (rw=1) consecutive addresses.
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   SCLK       in  SPI clock, idle low, asynchronous
//   SSEL       in  SPI select, active low, asynchronous
//   MOSI       in  SPI data in, MSB first
//   MISO       out SPI data out, MSB first, 0 while deselected
//   regs_flat  out all registers, reg[i] = regs_flat[8*i+7:8*i]
//   wr_strobe  out one-clock pulse the clock after a register is written
//   wr_addr    out address of the last write, valid while wr_strobe=1
//   busy       out high while the synchronised SSEL is low
//
// Handshake: there is no flow control. wr_strobe is a single-cycle pulse
// with wr_addr and the new register contents already stable on that cycle;
// consumers never back-pressure.
module spi_reg_bank
   import spi_regs_pkg::*;
#(
   parameter int         NUM_REGS  = 8,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  SCLK,
   input  logic                  SSEL,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic [NUM_REGS*8-1:0] regs_flat,
   output logic                  wr_strobe,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic                  busy
);

   // ---------------------------------------------------------------
   // Pin synchronisation
   // ---------------------------------------------------------------
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic ssel_lvl, ssel_rise, ssel_fall;
   logic mosi_meta_q, mosi_q;

   sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (SCLK),
      .level (sclk_lvl),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   sync_edge #(.RESET_VAL(1'b1)) u_ssel_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (SSEL),
      .level (ssel_lvl),
      .rise  (ssel_rise),
      .fall  (ssel_fall)
   );

   // MOSI gets the same two-flop delay as the SCLK level, so the bit seen
   // on a detected rise is the one the master set up before that rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_meta_q <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         mosi_meta_q <= MOSI;
         mosi_q      <= mosi_meta_q;
      end
   end

   // Level of SCLK and the SSEL rise pulse carry no extra information here:
   // the synced SSEL level already forces IDLE.
   logic unused_sync;
   assign unused_sync = sclk_lvl ^ ssel_rise;

   // ---------------------------------------------------------------
   // Bus FSM
   // ---------------------------------------------------------------
   spi_state_e state_q, state_d;

   logic [2:0]        bit_cnt_q;
   logic [6:0]        rx_q;
   logic [7:0]        rx_byte;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        tx_q;
   logic              load_pend_q;
   logic [7:0]        rd_data;

   logic start;
   logic cmd_done;
   logic data_done;
   logic shift_en;
   logic tx_fall;
   logic do_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      cmd_done  = 1'b0;
      data_done = 1'b0;
      // Synced SSEL high overrides everything, including a byte completing
      // on the same clock, so a truncated transaction never writes.
      if (ssel_lvl) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (ssel_fall) begin
                  state_d = CMD;
                  start   = 1'b1;
               end
            end
            CMD: begin
               if (sclk_rise && bit_cnt_q == 3'd7) begin
                  state_d  = DATA;
                  cmd_done = 1'b1;
               end
            end
            DATA: begin
               if (sclk_rise && bit_cnt_q == 3'd7) begin
                  data_done = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign shift_en = !ssel_lvl && (state_q != IDLE) && sclk_rise;
   assign tx_fall  = !ssel_lvl && (state_q != IDLE) && sclk_fall;
   assign rx_byte  = {rx_q, mosi_q};
   assign do_write = data_done && !rw_q && addr_mapped(addr_q, NUM_REGS);

   // ---------------------------------------------------------------
   // Shifters and address tracking
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q   <= 3'd0;
         rx_q        <= 7'd0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         tx_q        <= 8'h00;
         load_pend_q <= 1'b0;
      end else if (ssel_lvl || start) begin
         bit_cnt_q   <= 3'd0;
         rx_q        <= 7'd0;
         tx_q        <= 8'h00;
         load_pend_q <= 1'b0;
      end else begin
         if (shift_en) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            rx_q      <= rx_byte[6:0];
         end
         if (cmd_done) begin
            rw_q        <= rx_byte[CMD_RW_BIT];
            addr_q      <= rx_byte[ADDR_W-1:0];
            load_pend_q <= 1'b1;
         end
         // Burst auto-increment; 7-bit arithmetic wraps 127 -> 0.
         if (data_done) begin
            addr_q      <= addr_q + 7'd1;
            load_pend_q <= 1'b1;
         end
         // The first fall after a completed byte loads the next read value,
         // so its MSB is on MISO before the master's first rise of the byte.
         if (tx_fall) begin
            if (load_pend_q) begin
               tx_q        <= rd_data;
               load_pend_q <= 1'b0;
            end else begin
               tx_q <= {tx_q[6:0], 1'b0};
            end
         end
      end
   end

   assign MISO = tx_q[7];
   assign busy = ~ssel_lvl;

   // ---------------------------------------------------------------
   // Register array
   // ---------------------------------------------------------------
   logic [7:0] regs_q [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VAL;
         end
      end else if (do_write) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
               regs_q[i] <= rx_byte;
            end
         end
      end
   end

   // Unmapped addresses match no entry and read as zero; writes read zero.
   always_comb begin
      rd_data = 8'h00;
      if (rw_q) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
               rd_data = regs_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
      end else begin
         wr_strobe <= do_write;
         if (do_write) begin
            wr_addr <= addr_q;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[8*g +: 8] = regs_q[g];
   end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed transactions followed by
// random ones. A transaction-level model predicts register writes and the
// bytes returned on MISO; two monitors compare them against the DUT.
module tb_spi_reg_bank;

   localparam int NREG = 8;
   localparam int HALF = 6;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            sclk = 1'b0;
   logic            ssel = 1'b1;
   logic            mosi = 1'b0;
   logic            miso;
   logic [NREG*8-1:0] regs_flat;
   logic            wr_strobe;
   logic [6:0]      wr_addr;
   logic            busy;

   spi_reg_bank #(.NUM_REGS(NREG), .RESET_VAL(8'h00)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .SCLK      (sclk),
      .SSEL      (ssel),
      .MOSI      (mosi),
      .MISO      (miso),
      .regs_flat (regs_flat),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .busy      (busy)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected done");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;

   logic [14:0] exp_wr_q [$];   // {addr, data}
   logic [7:0]  exp_miso_q [$];
   logic [7:0]  m_regs [128];
   logic [7:0]  xfer_q [$];
   logic [7:0]  miso_byte;
   event        miso_ev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
   endtask

   task automatic model_xfer();
      logic       rw;
      int         a;
      logic [7:0] b;
      if (xfer_q.size() == 0) return;
      rw = xfer_q[0][7];
      a  = int'(xfer_q[0][6:0]);
      exp_miso_q.push_back(8'h00);
      for (int i = 1; i < xfer_q.size(); i++) begin
         b = xfer_q[i];
         if (rw) begin
            exp_miso_q.push_back(a < NREG ? m_regs[a] : 8'h00);
         end else begin
            exp_miso_q.push_back(8'h00);
            if (a < NREG) begin
               m_regs[a] = b;
               exp_wr_q.push_back({7'(a), b});
            end
         end
         a = (a + 1) % 128;
      end
   endtask

   // ---------------- driver ----------------
   task automatic spi_bit(input logic b, output logic m);
      mosi = b;
      wait_clk(HALF);
      m = miso;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
      logic m;
      r = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_bit(b[7-i], m);
         r = {r[6:0], m};
      end
   endtask

   task automatic run_xfer(input int abort_bits);
      logic [7:0] r;
      model_xfer();
      ssel = 1'b0;
      wait_clk(8);
      check("busy_active", busy, 1'b1);
      for (int i = 0; i < xfer_q.size(); i++) begin
         spi_byte(xfer_q[i], 8, r);
         miso_byte = r;
         -> miso_ev;
      end
      if (abort_bits > 0) spi_byte(8'hFF, abort_bits, r);
      wait_clk(HALF);
      ssel = 1'b1;
      wait_clk(10);
      check("busy_idle", busy, 1'b0);
      check("miso_idle", miso, 1'b0);
   endtask

   task automatic compare_regs(input string name);
      for (int i = 0; i < NREG; i++) begin
         check(name, regs_flat[8*i +: 8], m_regs[i]);
      end
   endtask

   // ---------------- monitors ----------------
   logic        prev_strobe = 1'b0;
   logic [14:0] mon_e;
   int          mon_a;

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_strobe && prev_strobe) check("strobe_back_to_back", 1, 0);
         if (wr_strobe) begin
            if (exp_wr_q.size() == 0) begin
               check("unexpected_strobe", {25'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
               mon_e = exp_wr_q.pop_front();
               mon_a = int'(mon_e[14:8]);
               check("wr_addr", wr_addr, mon_e[14:8]);
               check("wr_data", regs_flat[8*mon_a +: 8], mon_e[7:0]);
            end
         end
         prev_strobe = wr_strobe;
      end else begin
         prev_strobe = 1'b0;
      end
   end

   initial begin
      forever begin
         @(miso_ev);
         if (exp_miso_q.size() == 0) check("miso_unexpected", miso_byte, 32'hFFFF_FFFF);
         else check("miso_byte", miso_byte, exp_miso_q.pop_front());
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] r;
      int         n;
      logic [7:0] cmd;

      model_reset();
      wait_clk(4);
      check("reset_regs", regs_flat[31:0], 32'h0);
      check("reset_regs_hi", regs_flat[63:32], 32'h0);
      check("reset_miso", miso, 1'b0);
      check("reset_strobe", wr_strobe, 1'b0);
      check("reset_wr_addr", wr_addr, 7'd0);
      check("reset_busy", busy, 1'b0);
      rst_n = 1'b1;
      wait_clk(4);

      // single write
      xfer_q = {8'h01, 8'hA5};
      run_xfer(0);
      compare_regs("t1_regs");

      // read back
      xfer_q = {8'h81, 8'h00};
      run_xfer(0);

      // burst running past the end of the register range
      xfer_q = {8'h06, 8'h11, 8'h22, 8'h33};
      run_xfer(0);
      compare_regs("t3_regs");

      // partial byte discarded, then a full write
      xfer_q = {8'h02};
      run_xfer(5);
      compare_regs("t4a_regs");
      xfer_q = {8'h02, 8'h3C};
      run_xfer(0);
      compare_regs("t4b_regs");

      // unmapped read at 127 then wrap to 0
      xfer_q = {8'hFF, 8'h00, 8'h00};
      run_xfer(0);

      // reset in the middle of a data byte
      xfer_q = {8'h03, 8'h77};
      run_xfer(0);
      ssel = 1'b0;
      wait_clk(8);
      spi_byte(8'h04, 8, r);
      spi_byte(8'hAA, 4, r);
      rst_n = 1'b0;
      wait_clk(2);
      model_reset();
      compare_regs("t6_reset_regs");
      check("t6_reset_miso", miso, 1'b0);
      check("t6_reset_busy", busy, 1'b0);
      check("t6_reset_strobe", wr_strobe, 1'b0);
      sclk = 1'b0;
      ssel = 1'b1;
      mosi = 1'b0;
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(6);
      xfer_q = {8'h04, 8'h5A};
      run_xfer(0);
      compare_regs("t6_after_regs");

      // random transactions
      for (int t = 0; t < 30; t++) begin
         cmd[7] = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) cmd[6:0] = 7'($urandom_range(124, 127));
         else cmd[6:0] = 7'($urandom_range(0, 11));
         xfer_q = {cmd};
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) xfer_q.push_back(8'($urandom));
         run_xfer(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
      end

      wait_clk(20);
      check("wr_queue_drained", exp_wr_q.size(), 0);
      check("miso_queue_drained", exp_miso_q.size(), 0);
      compare_regs("final_regs");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
